cp0_vic: RTL
============

# cp0_vic

Parametrised successor to the pipeline's coprocessor 0: STATUS/CAUSE/EPC registers, N_IRQ maskable level interrupt lines with fixed priority, vectored entry addresses, ERET, and an optional COUNT/COMPARE timer interrupt. It sits beside the integer pipeline:
- MFC0 reads happen in ID.
- MTC0/ERET writes happen in EXE.
- Interrupts are taken against the MEM-stage instruction.
- jump_en/jump_addr redirect the fetch stage.

## Interface
Parameters:
- N_IRQ, 6, number of external interrupt lines; legal range 1..7.
- VEC_BASE, 32'h0000_0100, base of the interrupt vector table.
- VEC_SHIFT, 5, log2 byte stride between vector entries.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- oper  in  2  operation: 00 none, 01 MFC0 (read only), 10 MTC0, 11 ERET.
- addr_r  in  5  read register number.
- data_r  out  32  read data; combinational.
- addr_w  in  5  write register number.
- data_w  in  32  write data.
- ir_en  in  1  MEM stage holds a valid, interruptible instruction this cycle.
- ir_in  in  N_IRQ  external interrupt lines; active-high, level.
- ret_addr  in  32  address saved to EPC when an interrupt is taken.
- jump_en  out  1  registered one-cycle redirect pulse.
- jump_addr  out  32  registered redirect target.

## Operation
Register map (unlisted addresses read 0; writes to them are ignored):
- 9 COUNT: free-running up counter.
- 11 COMPARE: timer match value.
- 12 STATUS:
  - bit0 IE: global enable.
  - bit1 EXL: in handler.
  - bits[8+N_IRQ:8] IM: mask. Bit 8+N_IRQ masks the timer.
  - All other bits read 0.
- 13 CAUSE:
  - bits[8+N_IRQ:8] IP: read-only. ip_q plus timer flag TI at bit 8+N_IRQ.
  - bits[6:2] ExcCode: always 0 (interrupt).
  - CAUSE is read-only.
- 14 EPC: read/write.

Pending and take logic:
- ip_q <= ir_in every cycle.
- pend = {TI, ip_q} & IM.
- take = IE & ~EXL & ir_en & (pend != 0).
- Priority: highest set index of pend wins; the timer has the highest priority.

On take, at the next edge:
- EPC <= ret_addr.
- EXL <= 1.
- jump_en <= 1.
- jump_addr <= VEC_BASE + (idx << VEC_SHIFT).

ERET (oper==11), at the next edge:
- EXL <= 0.
- jump_en <= 1.
- jump_addr <= EPC.
- ERET has no effect on IE or IM.

Other rules:
- MTC0 updates the addressed register at the next edge.
- Read bypass: when oper==10 and addr_w==addr_r, data_r returns data_w masked to the writable fields.
- Operating mode is given by EXL: RUN (EXL=0) and HANDLER (EXL=1).
  - RUN→HANDLER on take.
  - HANDLER→RUN on ERET, or on an MTC0 to STATUS with bit1=0.
- jump_en is deasserted in every cycle with no take and no ERET.

Boundary conditions:
- Take and ERET in the same cycle cannot both fire, because take requires EXL=0 and an ERET only occurs with EXL=1. If software issues ERET with EXL=0, take wins and jump_addr is the vector.
- Take and an MTC0 to STATUS in the same cycle: take wins for EXL; IE and IM take data_w.
- Take and an MTC0 to EPC in the same cycle: take wins.
- An IRQ line deasserting before take: there is no latch, so the interrupt is lost.
- Asserting rst_n low mid-handler clears EXL and jump_en immediately.

## Timing
- Reset values:
  - STATUS, CAUSE, EPC, COUNT, ip_q, TI = 0.
  - COMPARE = 32'hFFFF_FFFF.
  - jump_en = 0, jump_addr = 0.
- Interrupt latency:
  - ir_in high before edge k gives ip_q=1 after edge k.
  - With IE/IM set, EXL=0 and ir_en=1 in cycle k, jump_en is high in the cycle after edge k+1.
- ERET latency: oper=11 in cycle k gives jump_en high in cycle k+1.
- jump_en is never high for two consecutive cycles from a single take. Back-to-back take→ERET→take is legal.

## Configuration
- CP0_TIMER_EN defined:
  - COUNT increments every cycle and wraps 32'hFFFF_FFFF→0.
  - An MTC0 to COUNT loads data_w and suppresses the increment that cycle.
  - TI is set at the edge where COUNT==COMPARE. TI is sticky and is cleared only by an MTC0 to COMPARE (or reset).
- CP0_TIMER_EN undefined:
  - COUNT, COMPARE and TI read 0; writes to them are ignored.
  - The timer bit of IP reads 0 and can never win priority.

## Test plan
- Reset → data_r=0 for STATUS, CAUSE and EPC; jump_en=0 with rst_n asserted asynchronously mid-cycle.
- N_IRQ=6. STATUS=32'h0000_3F01, ir_in=6'b000101, ir_en=1, ret_addr=32'h0000_0040 → 2 cycles later: jump_en pulse, jump_addr=32'h0000_0140 (idx 2), EPC=32'h40, STATUS reads 32'h0000_3F03.
- In HANDLER, ir_in=6'b111111 held; then ERET → no second take while EXL=1; jump_addr=32'h40 one cycle after ERET; take occurs 1 cycle after that.
- IM=8'h04 with ir_in=6'b001001 → idx 0 masked out, idx 3 masked out, no take. Then IM=8'h3F → jump_addr=VEC_BASE+3·32=32'h0000_0160.
- MTC0 EPC=32'h1234 in the same cycle as a take with ret_addr=32'h80 → EPC reads 32'h80.
- CP0_TIMER_EN: COMPARE=10, COUNT=0, IM bit 14 and IE set → TI set at COUNT==10, jump_addr=32'h0000_01C0. Writing COMPARE clears TI. Without the macro → no take, COUNT reads 0.

Source files
------------

// File: rtl/cp0_vic_if.sv
// ---------------------------------------------------------------------------
// cp0_vic_if
// Bus between the integer pipeline and the cp0_vic coprocessor.
//   master : pipeline side (drives operation, register numbers, write data,
//            interrupt lines and the return address; receives read data and
//            the fetch redirect)
//   slave  : cp0_vic side
// Signals:
//   oper      [1:0]      00 none, 01 MFC0, 10 MTC0, 11 ERET
//   addr_r    [4:0]      read register number (ID stage)
//   data_r    [31:0]     read data, combinational
//   addr_w    [4:0]      write register number (EXE stage)
//   data_w    [31:0]     write data
//   ir_en                MEM stage holds an interruptible instruction
//   ir_in     [N_IRQ-1:0] level interrupt lines, active high
//   ret_addr  [31:0]     address saved to EPC when an interrupt is taken
//   jump_en              one-cycle fetch redirect pulse (registered)
//   jump_addr [31:0]     redirect target (registered)
// ---------------------------------------------------------------------------
interface cp0_vic_if #(
  parameter int unsigned N_IRQ = 6
);
  logic [1:0]       oper;
  logic [4:0]       addr_r;
  logic [31:0]      data_r;
  logic [4:0]       addr_w;
  logic [31:0]      data_w;
  logic             ir_en;
  logic [N_IRQ-1:0] ir_in;
  logic [31:0]      ret_addr;
  logic             jump_en;
  logic [31:0]      jump_addr;

  modport master (
    output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    input  data_r, jump_en, jump_addr
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    output data_r, jump_en, jump_addr
  );
endinterface

// File: rtl/cp0_vic.sv
// ---------------------------------------------------------------------------
// cp0_vic
// Coprocessor 0 with vectored interrupts: STATUS / CAUSE / EPC, N_IRQ masked
// level interrupt lines with fixed priority (highest index wins), ERET, and
// an optional COUNT / COMPARE timer interrupt that outranks every line.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cp0_vic_if.slave (see rtl/cp0_vic_if.sv)
//
// Parameters:
//   N_IRQ      number of external interrupt lines (1..7)
//   VEC_BASE   base address of the vector table
//   VEC_SHIFT  log2 of the byte stride between vector entries
//
// Build option:
//   CP0_TIMER_EN  when defined, COUNT/COMPARE/TI are implemented; otherwise
//                 they read 0, ignore writes, and the timer never interrupts.
// ---------------------------------------------------------------------------
module cp0_vic #(
  parameter int unsigned N_IRQ     = 6,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int unsigned VEC_SHIFT = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  cp0_vic_if.slave bus
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MFC0 = 2'b01,
    OP_MTC0 = 2'b10,
    OP_ERET = 2'b11
  } oper_e;

  typedef enum logic [4:0] {
    REG_COUNT   = 5'd9,
    REG_COMPARE = 5'd11,
    REG_STATUS  = 5'd12,
    REG_CAUSE   = 5'd13,
    REG_EPC     = 5'd14
  } cp0_reg_e;

  // Operating mode mirrors STATUS.EXL.
  typedef enum logic {
    MODE_RUN     = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

  // IM / IP span the N_IRQ lines plus the timer bit on top.
  localparam int unsigned IMW  = N_IRQ + 1;
  localparam int unsigned IDXW = 3;

  localparam logic [31:0] STATUS_WMASK = {{(23 - N_IRQ){1'b0}}, {IMW{1'b1}}, 6'b0, 2'b11};
`ifdef CP0_TIMER_EN
  localparam logic [31:0] TIMER_WMASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TIMER_WMASK = 32'h0000_0000;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N_IRQ-1:0] r_ip_q;
  logic             r_ie;
  logic [IMW-1:0]   r_im;
  mode_e            r_mode;
  logic [31:0]      r_epc;
  logic             r_jump_en;
  logic [31:0]      r_jump_addr;

  logic [31:0]      w_count;
  logic [31:0]      w_compare;
  logic             w_ti;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  oper_e w_oper;
  logic  w_mtc0;
  logic  w_eret;
  logic  w_wr_status;
  logic  w_wr_epc;
  logic  w_exl;

  assign w_oper      = oper_e'(bus.oper);
  assign w_mtc0      = (w_oper == OP_MTC0);
  assign w_eret      = (w_oper == OP_ERET);
  assign w_wr_status = w_mtc0 && (bus.addr_w == REG_STATUS);
  assign w_wr_epc    = w_mtc0 && (bus.addr_w == REG_EPC);
  assign w_exl       = (r_mode == MODE_HANDLER);

  // -------------------------------------------------------------------------
  // Pending, take and priority
  // -------------------------------------------------------------------------
  logic [IMW-1:0]  w_pend;
  logic            w_take;
  logic [IDXW-1:0] w_idx;
  logic [31:0]     w_vec_addr;

  assign w_pend = {w_ti, r_ip_q} & r_im;
  assign w_take = r_ie && !w_exl && bus.ir_en && (w_pend != '0);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_idx = '0;
    // Ascending scan: the last (highest) set bit wins, so the timer on top
    // outranks every external line.
    for (int i = 0; i < int'(IMW); i++) begin
      if (w_pend[i]) w_idx = i[IDXW-1:0];
    end
  end

  assign w_vec_addr = VEC_BASE + ({{(32 - IDXW){1'b0}}, w_idx} << VEC_SHIFT);

  // -------------------------------------------------------------------------
  // Mode, STATUS, EPC, redirect
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ip_q      <= '0;
      r_ie        <= 1'b0;
      r_im        <= '0;
      r_mode      <= MODE_RUN;
      r_epc       <= '0;
      r_jump_en   <= 1'b0;
      r_jump_addr <= '0;
    end else begin
      r_ip_q    <= bus.ir_in;
      r_jump_en <= 1'b0;

      // IE/IM always follow an MTC0 to STATUS; only EXL competes with take.
      if (w_wr_status) begin
        r_ie <= bus.data_w[0];
        r_im <= bus.data_w[8 +: IMW];
      end

      if (w_take) begin
        r_epc       <= bus.ret_addr;
        r_mode      <= MODE_HANDLER;
        r_jump_en   <= 1'b1;
        r_jump_addr <= w_vec_addr;
      end else begin
        if (w_wr_epc) r_epc <= bus.data_w;

        if (w_eret) begin
          r_mode      <= MODE_RUN;
          r_jump_en   <= 1'b1;
          r_jump_addr <= r_epc;
        end else if (w_wr_status) begin
          r_mode <= bus.data_w[1] ? MODE_HANDLER : MODE_RUN;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional timer
  // -------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_wr_count   = w_mtc0 && (bus.addr_w == REG_COUNT);
  assign w_wr_compare = w_mtc0 && (bus.addr_w == REG_COMPARE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_compare <= 32'hFFFF_FFFF;
      r_ti      <= 1'b0;
    end else begin
      // A software load replaces that cycle's increment.
      if (w_wr_count) r_count <= bus.data_w;
      else            r_count <= r_count + 32'd1;

      if (w_wr_compare) r_compare <= bus.data_w;

      // TI is sticky; only rewriting COMPARE acknowledges it.
      if (w_wr_compare)              r_ti <= 1'b0;
      else if (r_count == r_compare) r_ti <= 1'b1;
    end
  end

  assign w_count   = r_count;
  assign w_compare = r_compare;
  assign w_ti      = r_ti;
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Read port
  // -------------------------------------------------------------------------
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_rd_raw;
  logic [31:0] w_wmask;
  logic        w_bypass;

  assign w_status = {{(23 - N_IRQ){1'b0}}, r_im, 6'b0, w_exl, r_ie};
  assign w_cause  = {{(23 - N_IRQ){1'b0}}, w_ti, r_ip_q, 8'b0};

  always_comb begin
    w_rd_raw = '0;
    w_wmask  = '0;
    case (bus.addr_r)
      REG_COUNT:   begin w_rd_raw = w_count;   w_wmask = TIMER_WMASK;  end
      REG_COMPARE: begin w_rd_raw = w_compare; w_wmask = TIMER_WMASK;  end
      REG_STATUS:  begin w_rd_raw = w_status;  w_wmask = STATUS_WMASK; end
      REG_CAUSE:   begin w_rd_raw = w_cause;   w_wmask = '0;           end
      REG_EPC:     begin w_rd_raw = r_epc;     w_wmask = '1;           end
      default:     begin w_rd_raw = '0;        w_wmask = '0;           end
    endcase
  end

  // Same-cycle MTC0 to the register being read: writable fields come from
  // data_w, read-only fields (e.g. all of CAUSE) keep their current value.
  assign w_bypass = w_mtc0 && (bus.addr_w == bus.addr_r);

  assign bus.data_r    = w_bypass ? ((bus.data_w & w_wmask) | (w_rd_raw & ~w_wmask))
                                  : w_rd_raw;
  assign bus.jump_en   = r_jump_en;
  assign bus.jump_addr = r_jump_addr;

endmodule
